spi_slave_regif: RTL and testbench

SPI responder that terminates host SPI frames and turns them into single-cycle register read/write requests on the internal register bus of the Fourier transform core.
- Sits between the pads (sck, ss_n, mosi, miso) and the register file: FREQ_n, DATA_n, NUM_SAMP, SAMP_FREQ, MODE, STATUS, EN_CORDIC, RESET_ALL.
- SCK is asynchronous to clk and oversampled, so SCK must be at least 8x slower than clk.

---
 rtl/spi_regif_pkg.sv | 24 ++
 rtl/spi_sync_edge.sv | 37 +++
 rtl/spi_slave_regif.sv | 208 ++++++++++++++++++++
 tb/tb_spi_slave_regif.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_regif_pkg.sv
// Frame layout, status-trailer bit positions and FSM states shared by the SPI register interface.
package spi_regif_pkg;

    localparam int HDR_BITS   = 16;
    localparam int DATA_BITS  = 32;
    localparam int STAT_BITS  = 8;
    localparam int FRAME_BITS = HDR_BITS + DATA_BITS + STAT_BITS;

    localparam int RW_BIT = HDR_BITS - 1;

    localparam int ST_MISALIGN   = 0;
    localparam int ST_RD_LATE    = 1;
    localparam int ST_ABORT_PREV = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_RD_WAIT,
        S_DATA,
        S_STAT,
        S_DONE
    } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pad input with one-clk rise/fall pulses.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   last_q, last_d;
    logic                   lvl;

    assign lvl = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
        last_d = lvl;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            last_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            last_q <= last_d;
        end
    end

    assign rise = lvl & ~last_q;
    assign fall = ~lvl & last_q;

endmodule

// File: rtl/spi_slave_regif.sv
// SPI mode-0 responder: decodes 56-bit host frames into single-cycle register bus reads/writes
// and returns read data plus a status trailer on miso.
module spi_slave_regif
    import spi_regif_pkg::*;
#(
    parameter int AW          = 15,
    parameter int DW          = 32,
    parameter int SYNC_STAGES = 2,
    parameter int SW          = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          spi_sck,
    input  logic          spi_ss_n,
    input  logic          spi_mosi,
    output logic          spi_miso,
    output logic [AW-1:0] reg_addr,
    output logic          reg_wr,
    output logic [DW-1:0] reg_wdata,
    output logic          reg_rd,
    input  logic [DW-1:0] reg_rdata,
    input  logic          reg_rvalid,
    output logic          busy
);

    state_e                 state_q, state_d;
    logic [5:0]             bit_cnt_q, bit_cnt_d, cnt_inc;
    logic [DW-2:0]          rx_q, rx_d;
    logic [DW-1:0]          rx_next, rd_word;
    logic [DW-1:0]          tx_q, tx_d;
    logic [DW-1:0]          wdata_q, wdata_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
    logic [SW-1:0]          stat_word;
    logic                   miso_q, miso_d;
    logic                   wr_q, wr_d, rd_q, rd_d;
    logic                   is_wr_q, is_wr_d;
    logic                   misalign_q, misalign_d;
    logic                   rd_late_q, rd_late_d;
    logic                   abort_prev_q, abort_prev_d;
    logic                   sck_rise, sck_fall, ss_rise, ss_fall, mosi_s;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk(clk), .rst(rst), .d(spi_sck), .rise(sck_rise), .fall(sck_fall)
    );

    // Reset value 0 means a host still holding ss_n low out of reset must release it
    // before a fall (new frame) can be seen.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ss_sync (
        .clk(clk), .rst(rst), .d(spi_ss_n), .rise(ss_rise), .fall(ss_fall)
    );

    assign mosi_d  = {mosi_q[SYNC_STAGES-2:0], spi_mosi};
    assign mosi_s  = mosi_q[SYNC_STAGES-1];
    assign rx_next = {rx_q, mosi_s};
    assign cnt_inc = (bit_cnt_q == 6'(FRAME_BITS)) ? bit_cnt_q : bit_cnt_q + 6'd1;
    assign rd_word = reg_rvalid ? reg_rdata : '0;

    always_comb begin
        stat_word                = '0;
        stat_word[ST_MISALIGN]   = misalign_q;
        stat_word[ST_RD_LATE]    = rd_late_q;
        stat_word[ST_ABORT_PREV] = abort_prev_q;
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        miso_d       = miso_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_d         = 1'b0;
        rd_d         = 1'b0;
        is_wr_d      = is_wr_q;
        misalign_d   = misalign_q;
        rd_late_d    = rd_late_q;
        abort_prev_d = abort_prev_q;

        if (sck_rise && (state_q inside {S_HDR, S_RD_WAIT, S_DATA, S_STAT})) begin
            bit_cnt_d = cnt_inc;
            rx_d      = rx_next[DW-2:0];
        end

        case (state_q)
            S_IDLE: begin
                if (ss_fall) begin
                    state_d    = S_HDR;
                    bit_cnt_d  = '0;
                    miso_d     = 1'b0;
                    tx_d       = '0;
                    is_wr_d    = 1'b0;
                    misalign_d = 1'b0;
                    rd_late_d  = 1'b0;
                end
            end
            S_HDR: begin
                if (sck_rise && cnt_inc == 6'(HDR_BITS)) begin
                    addr_d  = rx_next[AW-1:0];
                    is_wr_d = rx_next[RW_BIT];
                    tx_d    = '0;
                    if (rx_next[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = S_DATA;
                    end else if (!rx_next[RW_BIT]) begin
                        rd_d    = 1'b1;
                        state_d = S_RD_WAIT;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_RD_WAIT: begin
                // The first data bit is due on this fall; without data we send zeros.
                if (sck_fall) begin
                    miso_d    = rd_word[DW-1];
                    tx_d      = {rd_word[DW-2:0], 1'b0};
                    rd_late_d = ~reg_rvalid;
                    state_d   = S_DATA;
                end else if (reg_rvalid) begin
                    tx_d    = reg_rdata;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (sck_rise && cnt_inc == 6'(HDR_BITS + DATA_BITS)) begin
                    if (is_wr_q && !misalign_q) begin
                        wr_d    = 1'b1;
                        wdata_d = rx_next;
                    end
                    tx_d    = {stat_word, {(DW-SW){1'b0}}};
                    state_d = S_STAT;
                end else if (sck_fall) begin
                    miso_d = tx_q[DW-1];
                    tx_d   = {tx_q[DW-2:0], 1'b0};
                end
            end
            S_STAT: begin
                if (sck_rise && cnt_inc == 6'(FRAME_BITS)) begin
                    state_d = S_DONE;
                end else if (sck_fall) begin
                    miso_d = tx_q[DW-1];
                    tx_d   = {tx_q[DW-2:0], 1'b0};
                end
            end
            S_DONE: begin
                if (sck_fall) miso_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        // Deselect before the write commits is an abort; after it the frame simply ends.
        if (ss_rise && state_q != S_IDLE) begin
            abort_prev_d = state_q inside {S_HDR, S_RD_WAIT, S_DATA};
            state_d      = S_IDLE;
            miso_d       = 1'b0;
            wr_d         = 1'b0;
            rd_d         = 1'b0;
            is_wr_d      = 1'b0;
            misalign_d   = 1'b0;
            rd_late_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            rx_q         <= '0;
            tx_q         <= '0;
            miso_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_q         <= 1'b0;
            rd_q         <= 1'b0;
            is_wr_q      <= 1'b0;
            misalign_q   <= 1'b0;
            rd_late_q    <= 1'b0;
            abort_prev_q <= 1'b0;
            mosi_q       <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            miso_q       <= miso_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            is_wr_q      <= is_wr_d;
            misalign_q   <= misalign_d;
            rd_late_q    <= rd_late_d;
            abort_prev_q <= abort_prev_d;
            mosi_q       <= mosi_d;
        end
    end

    // Gate with the raw pad so miso is quiet the moment the host deselects.
    assign spi_miso  = miso_q & ~spi_ss_n;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_wr    = wr_q;
    assign reg_rd    = rd_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_slave_regif.sv
// Directed frame-level bench for spi_slave_regif: host SPI driver, register responder,
// frame-level reference model and a per-cycle bus/reset monitor.
module tb_spi_slave_regif;

    localparam int AW = 15;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          spi_sck = 1'b0;
    logic          spi_ss_n = 1'b1;
    logic          spi_mosi = 1'b0;
    logic          spi_miso;
    logic [AW-1:0] reg_addr;
    logic          reg_wr;
    logic [DW-1:0] reg_wdata;
    logic          reg_rd;
    logic [DW-1:0] reg_rdata = '0;
    logic          reg_rvalid = 1'b0;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int half_ns = 200;

    bit          resp_en = 1'b0;
    int          resp_lat = 0;
    logic [31:0] resp_data = '0;

    bit                   abort_prev_m = 1'b0;
    bit                   quiet_win = 1'b0;
    logic [AW+DW-1:0]     exp_wr_q[$];
    logic [AW-1:0]        exp_rd_q[$];

    always #5 clk = ~clk;

    spi_slave_regif dut (
        .clk(clk), .rst(rst),
        .spi_sck(spi_sck), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .reg_addr(reg_addr), .reg_wr(reg_wr), .reg_wdata(reg_wdata), .reg_rd(reg_rd),
        .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid), .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register responder: answers each reg_rd after resp_lat clocks (0 = same clock).
    initial begin
        forever begin
            @(negedge clk);
            if (reg_rd && resp_en) begin
                repeat (resp_lat) @(negedge clk);
                reg_rdata  = resp_data;
                reg_rvalid = 1'b1;
                @(negedge clk);
                reg_rvalid = 1'b0;
                reg_rdata  = '0;
            end
        end
    end

    // Bus monitor: strobes must match the model's expected transactions; reset and the
    // post-reset window must keep every output at 0.
    initial begin
        logic rst_e;
        logic wr_prev;
        logic [AW+DW-1:0] ew;
        logic [AW-1:0] er;
        wr_prev = 1'b0;
        forever begin
            @(posedge clk);
            rst_e = rst;
            @(negedge clk);
            if (rst_e || quiet_win) begin
                chk("rst_outputs_zero", {reg_wr, reg_rd, busy, spi_miso, reg_addr, reg_wdata}, '0);
            end else begin
                if (reg_wr) begin
                    chk("wr_single_cycle", wr_prev, 1'b0);
                    if (exp_wr_q.size() == 0) chk("wr_unexpected", reg_wr, 1'b0);
                    else if (!wr_prev) begin
                        ew = exp_wr_q.pop_front();
                        chk("wr_addr", reg_addr, ew[AW+DW-1:DW]);
                        chk("wr_data", reg_wdata, ew[DW-1:0]);
                    end
                end
                if (reg_rd) begin
                    if (exp_rd_q.size() == 0) chk("rd_unexpected", reg_rd, 1'b0);
                    else begin
                        er = exp_rd_q.pop_front();
                        chk("rd_addr", reg_addr, er);
                    end
                end
                if (spi_ss_n) chk("miso_deselected", spi_miso, 1'b0);
            end
            wr_prev = reg_wr;
        end
    end

    // One host frame of nbits bits; rst_bit >= 0 pulses rst for 5 clk before that bit.
    task automatic run(input logic [15:0] hdr, input logic [31:0] wd, input int nbits,
                       input int rst_bit, input bit ren, input int lat, input logic [31:0] rdat,
                       output logic [31:0] rd_got, output logic [7:0] st_got);
        bit          wr, al, in_time, full;
        logic [31:0] exp_rd;
        logic [7:0]  exp_st;
        logic [63:0] fb, rx;
        wr      = hdr[15];
        al      = (hdr[1:0] == 2'b00);
        full    = (nbits >= 56) && (rst_bit < 0);
        in_time = ren && ((lat + 4) * 10 < half_ns);
        exp_rd  = (!wr && al && in_time) ? rdat : 32'h0;
        exp_st  = {5'b0, abort_prev_m, (!wr && al && !in_time), !al};
        if (rst_bit < 0) begin
            if (wr && al && nbits >= 48) exp_wr_q.push_back({hdr[14:0], wd});
            if (!wr && al && nbits >= 16) exp_rd_q.push_back(hdr[14:0]);
        end
        resp_en   = ren;
        resp_lat  = lat;
        resp_data = rdat;
        fb = {hdr, wd, 8'h00, 8'hFF};
        rx = '0;
        spi_ss_n = 1'b0;
        #(half_ns);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) begin
                @(posedge clk); #1 rst = 1'b1;
                @(posedge clk); #1 quiet_win = 1'b1;
                repeat (4) @(posedge clk);
                #1 rst = 1'b0;
            end
            spi_mosi = fb[63-i];
            #(half_ns);
            spi_sck = 1'b1;
            rx[63-i] = spi_miso;
            if (i == 32 && rst_bit < 0) chk("busy_in_frame", busy, 1'b1);
            #(half_ns);
            spi_sck = 1'b0;
        end
        #(half_ns);
        spi_ss_n = 1'b1;
        repeat (30) @(posedge clk);
        #1 quiet_win = 1'b0;
        abort_prev_m = (rst_bit >= 0) ? 1'b0 : (nbits < 48);
        rd_got = rx[47:16];
        st_got = rx[15:8];
        if (full) begin
            chk("hdr_phase_miso", rx[63:48], 16'h0);
            chk("host_rdata", rd_got, exp_rd);
            chk("host_trailer", st_got, exp_st);
            if (nbits > 56) chk("extra_bits_miso", rx[7:0], 8'h00);
        end
        if (rst_bit >= 0) chk("rst_frame_miso", rx, 64'h0);
        chk("busy_after_frame", busy, 1'b0);
        chk("wr_missing", exp_wr_q.size(), 0);
        chk("rd_missing", exp_rd_q.size(), 0);
        exp_wr_q.delete();
        exp_rd_q.delete();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic [7:0]  st;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("idle_busy", busy, 1'b0);
        chk("idle_addr", reg_addr, 15'h0);

        // 1: write 0x0010 at 1 us SCK
        half_ns = 500;
        run(16'h8010, 32'h0000_1388, 56, -1, 1'b0, 0, 32'h0, rd, st);
        chk("t1_addr", reg_addr, 15'h0010);
        chk("t1_wdata", reg_wdata, 32'h0000_1388);
        chk("t1_trailer", st, 8'h00);

        // top aligned address, extra clocks past the frame
        half_ns = 200;
        run(16'hFFFC, 32'h8000_0001, 60, -1, 1'b0, 0, 32'h0, rd, st);
        chk("top_addr", reg_addr, 15'h7FFC);
        chk("top_wdata", reg_wdata, 32'h8000_0001);

        // 2: read with 3-clk latency; mosi ones must be ignored
        run(16'h0080, 32'hFFFF_FFFF, 56, -1, 1'b1, 3, 32'hA5A5_0F0F, rd, st);
        chk("t2_rdata", rd, 32'hA5A5_0F0F);
        chk("t2_trailer", st, 8'h00);

        // rvalid in the same clk as reg_rd
        run(16'h0088, 32'h0, 56, -1, 1'b1, 0, 32'h1234_5678, rd, st);
        chk("same_clk_rdata", rd, 32'h1234_5678);

        // 3: no rvalid at all, then rvalid arriving long after the deadline
        run(16'h0084, 32'h0, 56, -1, 1'b0, 0, 32'h0, rd, st);
        chk("t3_rdata", rd, 32'h0);
        chk("t3_trailer", st, 8'h02);
        run(16'h0084, 32'h0, 56, -1, 1'b1, 300, 32'hDEAD_BEEF, rd, st);
        chk("late_rdata", rd, 32'h0);
        chk("late_trailer", st, 8'h02);

        // 4: misaligned write
        run(16'h8013, 32'h5555_AAAA, 56, -1, 1'b0, 0, 32'h0, rd, st);
        chk("t4_trailer", st, 8'h01);

        // 5: aborted write, read reports it, next read is clean
        run(16'h8020, 32'h1234_0000, 20, -1, 1'b0, 0, 32'h0, rd, st);
        run(16'h0080, 32'h0, 56, -1, 1'b1, 3, 32'h0BAD_CAFE, rd, st);
        chk("t5_rdata", rd, 32'h0BAD_CAFE);
        chk("t5_trailer", st, 8'h04);
        run(16'h0080, 32'h0, 56, -1, 1'b1, 3, 32'h600D_F00D, rd, st);
        chk("t5c_trailer", st, 8'h00);

        // 6: reset at bit 30 of a write, then a clean write
        run(16'h8010, 32'h1111_2222, 56, 30, 1'b0, 0, 32'h0, rd, st);
        chk("t6_addr_after_rst", reg_addr, 15'h0);
        run(16'h8040, 32'hCAFE_F00D, 56, -1, 1'b0, 0, 32'h0, rd, st);
        chk("t6_trailer", st, 8'h00);
        chk("t6_addr", reg_addr, 15'h0040);
        chk("t6_wdata", reg_wdata, 32'hCAFE_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
